// File: rtl/c1_bus_frontend.sv
// c1_bus_frontend
//   Cache-side front end for the CPU<->cache C1 bus. Captures the CPU's
//   two-cycle command/address (and write-data) phase, issues one parallel
//   request to the cache core, then drives the response phase back onto
//   C1/D1 and releases the bus through a single turnaround cycle.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   c1_in/out/oe        C1 command bus (split tri-state)
//   a1_in               A1 address bus
//   d1_in/out/oe        D1 data bus (split tri-state)
//   req_*               request to cache core (valid/ready handshake)
//   resp_valid/rdata    one-cycle completion pulse from cache core
//   busy                high whenever the block is not idle
//   txn_count           completed transactions, wrapping
module c1_bus_frontend #(
  parameter int OFFSET_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          c1_in,
  output logic [2:0]          c1_out,
  output logic                c1_oe,
  input  logic [14:0]         a1_in,
  input  logic [15:0]         d1_in,
  output logic [15:0]         d1_out,
  output logic                d1_oe,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [2:0]          req_cmd,
  output logic [14:0]         req_tag_set,
  output logic [OFFSET_W-1:0] req_offset,
  output logic [31:0]         req_wdata,
  input  logic                resp_valid,
  input  logic [31:0]         resp_rdata,
  output logic                busy,
  output logic [CNT_W-1:0]    txn_count
);

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_READ32  = 3'd3;
  localparam logic [2:0] CMD_WRITE32 = 3'd7;
  localparam logic [2:0] CMD_RESP    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR2, S_ISSUE, S_WAIT, S_RESP1, S_RESP2, S_TURN
  } state_e;

  state_e              state_q;
  logic [2:0]          c1_out_q;
  logic                c1_oe_q;
  logic [15:0]         d1_out_q;
  logic                d1_oe_q;
  logic                req_valid_q;
  logic [2:0]          req_cmd_q;
  logic [14:0]         req_tag_set_q;
  logic [OFFSET_W-1:0] req_offset_q;
  logic [31:0]         req_wdata_q;
  logic [15:0]         rdata_hi_q;   // upper read half, replayed in RESP2
  logic [CNT_W-1:0]    txn_count_q;
  logic [CNT_W-1:0]    txn_count_d;

  // READ8/16/32 are codes 1..3, writes are 5..7.
  function automatic logic is_read(input logic [2:0] c);
    return (c != CMD_NOP) && !c[2];
  endfunction

  function automatic logic is_write(input logic [2:0] c);
    return c[2] && (c[1:0] != 2'b00);
  endfunction

  assign txn_count_d = txn_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      c1_out_q      <= CMD_NOP;
      c1_oe_q       <= 1'b0;
      d1_out_q      <= '0;
      d1_oe_q       <= 1'b0;
      req_valid_q   <= 1'b0;
      req_cmd_q     <= '0;
      req_tag_set_q <= '0;
      req_offset_q  <= '0;
      req_wdata_q   <= '0;
      rdata_hi_q    <= '0;
      txn_count_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Exact-match case: NOP and any X/Z pattern fall to default.
          case (c1_in)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7: begin
              req_cmd_q     <= c1_in;
              req_tag_set_q <= a1_in;
              req_wdata_q   <= {16'h0000, is_write(c1_in) ? d1_in : 16'h0000};
              state_q       <= S_ADDR2;
            end
            default: ;
          endcase
        end

        S_ADDR2: begin
          req_offset_q <= a1_in[OFFSET_W-1:0];
          if (req_cmd_q == CMD_WRITE32) req_wdata_q[31:16] <= d1_in;
          req_valid_q  <= 1'b1;
          c1_oe_q      <= 1'b1;       // hold C1 busy with NOP until response
          c1_out_q     <= CMD_NOP;
          state_q      <= S_ISSUE;
        end

        S_ISSUE: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (resp_valid) begin
            c1_out_q <= CMD_RESP;
            if (is_read(req_cmd_q)) begin
              d1_oe_q    <= 1'b1;
              d1_out_q   <= resp_rdata[15:0];
              rdata_hi_q <= resp_rdata[31:16];
            end
            state_q <= S_RESP1;
          end
        end

        S_RESP1: begin
          if (req_cmd_q == CMD_READ32) begin
            d1_out_q <= rdata_hi_q;
            state_q  <= S_RESP2;
          end else begin
            c1_oe_q  <= 1'b0;
            c1_out_q <= CMD_NOP;
            d1_oe_q  <= 1'b0;
            d1_out_q <= '0;
            state_q  <= S_TURN;
          end
        end

        S_RESP2: begin
          c1_oe_q  <= 1'b0;
          c1_out_q <= CMD_NOP;
          d1_oe_q  <= 1'b0;
          d1_out_q <= '0;
          state_q  <= S_TURN;
        end

        S_TURN: begin
          txn_count_q <= txn_count_d;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign c1_out      = c1_out_q;
  assign c1_oe       = c1_oe_q;
  assign d1_out      = d1_out_q;
  assign d1_oe       = d1_oe_q;
  assign req_valid   = req_valid_q;
  assign req_cmd     = req_cmd_q;
  assign req_tag_set = req_tag_set_q;
  assign req_offset  = req_offset_q;
  assign req_wdata   = req_wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign txn_count   = txn_count_q;

endmodule

// File: doc/c1_bus_frontend.md
# c1_bus_frontend

Cache-side front end for the CPU↔cache C1 bus. It captures the CPU's two-cycle command/address (and write-data) phase, issues a single parallel request to the cache core, and drives the response phase back onto C1/D1, owning bus turnaround. It sits directly downstream of the CPU bus master and upstream of the cache core lookup logic.

## Interface
Parameters:
- OFFSET_W, 4, cache-line offset bits carried on A1 in the second address cycle
- CNT_W, 16, width of the completed-transaction counter

Ports (the C1/D1 inouts are split into in/out/oe; the tri-state buffers sit at the top level):
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- c1_in  in  3  C1 as seen on the bus
- c1_out  out  3  value this block drives on C1
- c1_oe  out  1  1 = this block drives C1
- a1_in  in  15  A1 address bus
- d1_in  in  16  D1 as seen on the bus
- d1_out  out  16  value this block drives on D1
- d1_oe  out  1  1 = this block drives D1
- req_valid  out  1  request to cache core is pending
- req_ready  in  1  core accepts the request
- req_cmd  out  3  captured C1 command code
- req_tag_set  out  15  first-cycle A1 (tag + set)
- req_offset  out  OFFSET_W  second-cycle A1[OFFSET_W-1:0]
- req_wdata  out  32  write data {high word, low word}
- resp_valid  in  1  core completed the request (one-cycle pulse)
- resp_rdata  in  32  read data, right-aligned for READ8/16
- busy  out  1  1 whenever state != IDLE
- txn_count  out  CNT_W  completed transactions, wraps modulo 2^CNT_W

## Operation
- Command codes: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7; RESPONSE=7 (direction disambiguates).
- States: IDLE, ADDR2, ISSUE, WAIT, RESP1, RESP2, TURN.
- IDLE: if c1_in is 1..7 → latch req_cmd, req_tag_set=a1_in; for writes also latch req_wdata[15:0]=d1_in → ADDR2. NOP or any X/Z value: stay.
- ADDR2: latch req_offset=a1_in[OFFSET_W-1:0]; for WRITE32 also latch req_wdata[31:16]=d1_in → ISSUE. For WRITE8/16, req_wdata[31:16] is 0.
- ISSUE: req_valid=1; on req_ready=1 → WAIT. Request fields are held stable while req_valid=1.
- WAIT: on resp_valid=1 → RESP1. resp_valid in any other state is ignored.
- RESP1: c1_out=RESPONSE; for reads d1_oe=1, d1_out=latched rdata[15:0]. READ32 → RESP2, else → TURN.
- RESP2: c1_out=RESPONSE, d1_oe=1, d1_out=rdata[31:16] → TURN.
- TURN: c1_oe=0, d1_oe=0 for one cycle; txn_count increments → IDLE.
- c1_oe=1 with c1_out=NOP in ISSUE and WAIT (cache holds the bus busy); c1_oe=0 in IDLE, ADDR2 and TURN.
- c1_in is never decoded while c1_oe=1.
- resp_rdata is latched on the resp_valid cycle; for writes and invalidates it is ignored and d1_oe stays 0.

## Timing
- Reset (async, immediate): state=IDLE; c1_oe=0, d1_oe=0, c1_out=0, d1_out=0, req_valid=0, req_cmd=0, req_tag_set=0, req_offset=0, req_wdata=0, busy=0, txn_count=0. Asserting reset mid-transaction aborts it and releases the bus in the same cycle, with no count.
- Command seen at edge T0, offset at T1, req_valid high from T1+ (after the T1 edge). With req_ready=1 at edge T2, the block is in WAIT after T2.
- resp_valid sampled at edge Tr → RESPONSE driven during Tr..Tr+1, and additionally Tr+1..Tr+2 for READ32. The TURN cycle follows, and a new command is accepted at the next edge after TURN.
- Minimum transaction: 6 cycles (non-READ32, req_ready and resp_valid first possible).
- txn_count increments at the TURN→IDLE edge; 0xFFFF+1 → 0x0000.

## Test plan
- READ8 tag_set=0x0003, offset=0x2; core req_ready at once, resp_valid after 3 cycles with rdata=0x000000A5 → req_cmd=1, req_tag_set=0x0003, req_offset=2; exactly one RESPONSE cycle with d1_out=0x00A5; txn_count=1.
- READ32 at 0x1234/0xF with rdata=0xDEADBEEF → two RESPONSE cycles, d1_out=0xBEEF then 0xDEAD; then TURN with both oe=0.
- WRITE32 with d1=0x5678 then 0x1234 → req_wdata=0x12345678; the RESPONSE cycle has d1_oe=0.
- req_ready held low for 5 cycles → req_valid stays high with fields stable, c1_out=NOP driven; resp_valid pulsed during ISSUE is ignored.
- Reset asserted during WAIT → c1_oe=0, d1_oe=0, busy=0 immediately; txn_count unchanged from its pre-reset value of 0; a following READ16 completes normally.
- X/Z or NOP on c1_in in IDLE → no transaction. Running 65536 transactions → txn_count wraps to 0.
